line_mem_responder: RTL and testbench

//  Responder end of the L1 line req/ack protocol: a latency-configurable 256-bit line memory

---
 rtl/cache_pkg.sv | 15 +
 rtl/line_store.sv | 42 ++++
 rtl/line_mem_responder.sv | 112 +++++++++++
 tb/tb_line_mem_responder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and default sizes for the line memory responder
package cache_pkg;

  localparam int CACHE_LINE_W = 256;
  localparam int CACHE_ADDR_W = 11;
  localparam int CNT_W        = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    RECOVER
  } resp_state_t;

endpackage

// File: rtl/line_store.sv
// rtl/line_store.sv - line array with per-line valid bits and registered read port
module line_store
  import cache_pkg::*;
#(
  parameter int ADDR_W = CACHE_ADDR_W,
  parameter int LINE_W = CACHE_LINE_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata,
  output logic              hit
);

  logic [LINE_W-1:0]      mem [2**ADDR_W];
  logic [2**ADDR_W-1:0]   valid;
  logic [LINE_W-1:0]      raw_q;
  logic                   hit_q;

  // Array and raw read register carry no reset so they can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= wdata;
    if (rd_en) raw_q <= mem[addr];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid <= '0;
      hit_q <= 1'b0;
    end else begin
      if (wr_en) valid[addr] <= 1'b1;
      if (rd_en) hit_q <= valid[addr];
    end
  end

  assign rdata = raw_q;
  assign hit   = hit_q;

endmodule

// File: rtl/line_mem_responder.sv
// rtl/line_mem_responder.sv - latency-configurable single-outstanding line memory responder
module line_mem_responder
  import cache_pkg::*;
#(
  parameter int ADDR_W  = CACHE_ADDR_W,
  parameter int LINE_W  = CACHE_LINE_W,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LINE_W-1:0] wdata,
  output logic              ack,
  output logic              ready_o,
  output logic [LINE_W-1:0] rdata
);

  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("line_mem_responder: LATENCY must be within 1..15");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  resp_state_t       state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              commit;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              op_we;
  logic [ADDR_W-1:0] op_addr;
  logic [LINE_W-1:0] op_wdata;
  logic [LINE_W-1:0] store_rdata;
  logic              store_hit;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    commit  = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (LATENCY == 1) begin
            state_n = RESP;
            commit  = 1'b1;
          end else begin
            state_n = WAIT;
            cnt_n   = CNT_W'(LATENCY - 2);
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_n = RESP;
          commit  = 1'b1;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      RESP:    state_n = RECOVER;
      RECOVER: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Request registers are only loaded on accept; input changes afterwards are ignored.
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      we_q    <= we;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

  // With LATENCY==1 the commit happens on the accept edge, before the request regs load.
  assign op_we    = (state == IDLE) ? we    : we_q;
  assign op_addr  = (state == IDLE) ? addr  : addr_q;
  assign op_wdata = (state == IDLE) ? wdata : wdata_q;

  line_store #(
    .ADDR_W(ADDR_W),
    .LINE_W(LINE_W)
  ) u_store (
    .clk   (clk),
    .rstn  (rstn),
    .wr_en (rstn & commit & op_we),
    .rd_en (rstn & commit & ~op_we),
    .addr  (op_addr),
    .wdata (op_wdata),
    .rdata (store_rdata),
    .hit   (store_hit)
  );

  assign ack     = (state == RESP);
  assign ready_o = (state == IDLE);
  assign rdata   = store_hit ? store_rdata : '0;

endmodule

// File: tb/tb_line_mem_responder.sv
// tb/tb_line_mem_responder.sv - randomized self-checking bench with a behavioural line memory model
module tb_line_mem_responder;

  localparam int AW  = 11;
  localparam int LW  = 256;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          req = 1'b0, we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [LW-1:0] wdata = '0;
  logic          ack, ready_o;
  logic [LW-1:0] rdata;

  logic          req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr1 = '0;
  logic [LW-1:0] wdata1 = '0;
  logic          ack1, ready1;
  logic [LW-1:0] rdata1;

  int checks = 0;
  int errors = 0;

  logic [LW-1:0] model [int];
  logic [LW-1:0] rd_exp = '0;

  line_mem_responder #(.ADDR_W(AW), .LINE_W(LW), .LATENCY(LAT)) dut (
    .clk(clk), .rstn(rstn), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .ready_o(ready_o), .rdata(rdata)
  );

  line_mem_responder #(.ADDR_W(AW), .LINE_W(LW), .LATENCY(1)) dut1 (
    .clk(clk), .rstn(rstn), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
    .ack(ack1), .ready_o(ready1), .rdata(rdata1)
  );

  always #5 clk = ~clk;

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [LW-1:0] model_read(input logic [AW-1:0] a);
    if (model.exists(int'(a))) return model[int'(a)];
    return '0;
  endfunction

  // One full transaction on the LATENCY=LAT port, checking ack/ready timing and rdata.
  task automatic op(input logic w, input logic [AW-1:0] a, input logic [LW-1:0] d,
                    input bit late, input bit scramble);
    int pulses = 0;
    int waitc = 0;
    logic [LW-1:0] exp;
    while (ready_o !== 1'b1 && waitc < 20) begin
      @(posedge clk); #1; waitc++;
    end
    checks++;
    if (ready_o !== 1'b1) begin
      errors++; $display("FAIL ready_before_req got %b exp 1", ready_o);
    end
    exp = w ? rd_exp : model_read(a);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk); #1;
    for (int k = 0; k <= LAT + 1; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      checks++;
      if (ack !== (k == LAT - 1)) begin
        errors++; $display("FAIL ack_timing k=%0d got %b exp %b", k, ack, (k == LAT - 1));
      end
      if (ack === 1'b1) pulses++;
      checks++;
      if (ready_o !== (k == LAT + 1)) begin
        errors++; $display("FAIL ready_timing k=%0d got %b exp %b", k, ready_o, (k == LAT + 1));
      end
      if (k == LAT - 1) begin
        checks++;
        if (rdata !== exp) begin
          errors++; $display("FAIL rdata_at_ack addr=%0d got %h exp %h", a, rdata, exp);
        end
      end
      if (k == 0 && scramble) begin
        addr = a ^ AW'(7); wdata = ~d; we = ~w;
      end
      if (k == LAT && !late) req = 1'b0;
      if (k == LAT + 1 && late) req = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      checks++;
      if (ack !== 1'b0) begin
        errors++; $display("FAIL ack_after_done got %b exp 0", ack);
      end
      if (ack === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL ack_pulse_count got %0d exp 1", pulses);
    end
    if (w) model[int'(a)] = d;
    else rd_exp = exp;
    checks++;
    if (rdata !== rd_exp) begin
      errors++; $display("FAIL rdata_hold got %h exp %h", rdata, rd_exp);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; req = 1'b1; we = 1'b1; addr = AW'(5); wdata = rand_line();
    req1 = 1'b1; we1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ack !== 1'b0 || ready_o !== 1'b1 || rdata !== '0) begin
        errors++; $display("FAIL reset_outputs ack=%b ready=%b rdata=%h exp 0 1 0", ack, ready_o, rdata);
      end
      checks++;
      if (ack1 !== 1'b0 || ready1 !== 1'b1 || rdata1 !== '0) begin
        errors++; $display("FAIL reset_outputs_l1 ack=%b ready=%b rdata=%h exp 0 1 0", ack1, ready1, rdata1);
      end
    end
    req = 1'b0; req1 = 1'b0;
    rstn = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ready_o !== 1'b1 || ack !== 1'b0) begin
      errors++; $display("FAIL reset_no_accept ready=%b ack=%b exp 1 0", ready_o, ack);
    end
    model.delete();
    rd_exp = '0;
  endtask

  task automatic test_write_read();
    op(1'b1, AW'(400), LW'(256'h101), 1'b0, 1'b0);
    op(1'b0, AW'(400), rand_line(), 1'b0, 1'b0);
    checks++;
    if (rdata !== LW'(256'h101)) begin
      errors++; $display("FAIL read_400 got %h exp 101", rdata);
    end
  endtask

  task automatic test_unwritten();
    op(1'b0, AW'(401), rand_line(), 1'b0, 1'b0);
    op(1'b1, AW'(401), LW'(256'h202), 1'b0, 1'b0);
    op(1'b0, AW'(401), '0, 1'b0, 1'b0);
  endtask

  task automatic test_late_drop();
    op(1'b1, AW'(12), rand_line(), 1'b1, 1'b0);
    op(1'b0, AW'(12), rand_line(), 1'b1, 1'b0);
  endtask

  task automatic test_input_change();
    op(1'b1, AW'(0), rand_line(), 1'b0, 1'b1);
    op(1'b0, AW'(7), '0, 1'b0, 1'b0);
    op(1'b0, AW'(0), '0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_abort();
    int seen = 0;
    req = 1'b1; we = 1'b1; addr = AW'(3); wdata = LW'(256'hABC);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 1'b0; req = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int i = 0; i < LAT + 2; i++) begin
      if (ack === 1'b1) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0 || ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_abort acks=%0d ready=%b exp 0 1", seen, ready_o);
    end
    model.delete();
    rd_exp = '0;
    op(1'b0, AW'(3), rand_line(), 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      logic [AW-1:0] a;
      a = ($urandom_range(0, 7) == 0) ? AW'(2047) : AW'($urandom_range(0, 15));
      op(1'($urandom_range(0, 1)), a, rand_line(), 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    logic [LW-1:0] d;
    for (int i = 0; i < 4; i++) begin
      d = rand_line();
      op(1'b1, AW'(100 + i), d, 1'b0, 1'b0);
      op(1'b0, AW'(100 + i), '0, 1'b0, 1'b0);
      checks++;
      if (rdata !== d) begin
        errors++; $display("FAIL back_to_back i=%0d got %h exp %h", i, rdata, d);
      end
    end
  endtask

  task automatic l1_access(input logic w, input logic [LW-1:0] d, input logic [LW-1:0] exp_rd);
    req1 = 1'b1; we1 = w; addr1 = AW'(2047); wdata1 = d;
    @(posedge clk); #1;
    checks++;
    if (ack1 !== 1'b1 || ready1 !== 1'b0) begin
      errors++; $display("FAIL l1_ack_timing ack=%b ready=%b exp 1 0", ack1, ready1);
    end
    checks++;
    if (rdata1 !== exp_rd) begin
      errors++; $display("FAIL l1_rdata got %h exp %h", rdata1, exp_rd);
    end
    @(posedge clk); #1;
    req1 = 1'b0;
    checks++;
    if (ack1 !== 1'b0 || ready1 !== 1'b0) begin
      errors++; $display("FAIL l1_recover ack=%b ready=%b exp 0 0", ack1, ready1);
    end
    @(posedge clk); #1;
    checks++;
    if (ready1 !== 1'b1 || ack1 !== 1'b0) begin
      errors++; $display("FAIL l1_idle ack=%b ready=%b exp 0 1", ack1, ready1);
    end
  endtask

  task automatic test_latency1();
    l1_access(1'b1, '1, '0);
    l1_access(1'b0, '0, '1);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_unwritten();
    test_late_drop();
    test_input_change();
    test_reset_abort();
    test_back_to_back();
    test_random();
    test_latency1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
